// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared pipeline-stage constants and the stage entry layout.
package cpu_pipe_pkg;
   localparam int ADDR_W_DEF = 15;
   localparam int DATA_W_DEF = 32;
   localparam int INST_W_DEF = 32;
   localparam logic [INST_W_DEF-1:0] NOP_INST = 32'h00000013;
   typedef struct packed {
      logic [ADDR_W_DEF-1:0] pc;
      logic [INST_W_DEF-1:0] inst;
      logic [DATA_W_DEF-1:0] data0;
      logic [DATA_W_DEF-1:0] data1;
   } stage_entry_t;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one entry register with valid, load, drop, clear-to-NOP and sync reset.
module pipe_slot
   import cpu_pipe_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int INST_W = INST_W_DEF,
   parameter logic [INST_W-1:0] NOP = INST_W'(cpu_pipe_pkg::NOP_INST)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic              drop,
   input  logic [ADDR_W-1:0] d_pc,
   input  logic [INST_W-1:0] d_inst,
   input  logic [DATA_W-1:0] d_data0,
   input  logic [DATA_W-1:0] d_data1,
   output logic              valid,
   output logic [ADDR_W-1:0] pc,
   output logic [INST_W-1:0] inst,
   output logic [DATA_W-1:0] data0,
   output logic [DATA_W-1:0] data1
);
   // clear keeps pc/data so downstream sees stable values while invalid
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         pc    <= '0;
         inst  <= NOP;
         data0 <= '0;
         data1 <= '0;
      end else if (clear) begin
         valid <= 1'b0;
         inst  <= NOP;
      end else if (load) begin
         valid <= 1'b1;
         pc    <= d_pc;
         inst  <= d_inst;
         data0 <= d_data0;
         data1 <= d_data1;
      end else if (drop) begin
         valid <= 1'b0;
      end
   end
endmodule

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: valid/ready pipeline stage register with a one-entry skid slot.
// Optional perf counters enabled by defining PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_skid_reg
   import cpu_pipe_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int INST_W = INST_W_DEF,
   parameter logic [INST_W-1:0] NOP_INST = INST_W'(cpu_pipe_pkg::NOP_INST)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic [INST_W-1:0] in_inst,
   input  logic [DATA_W-1:0] in_data0,
   input  logic [DATA_W-1:0] in_data1,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_pc,
   output logic [INST_W-1:0] out_inst,
   output logic [DATA_W-1:0] out_data0,
`ifdef PIPE_STAGE_PERF_CNT_EN
   output logic [DATA_W-1:0] out_data1,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_bubble_cnt
`else
   output logic [DATA_W-1:0] out_data1
`endif
);
   logic              s_valid;
   logic [ADDR_W-1:0] s_pc;
   logic [INST_W-1:0] s_inst;
   logic [DATA_W-1:0] s_data0, s_data1;
   logic              m_free, acc, m_load, s_load, s_drop, rdy;
   // in_ready == !s_valid, so an accept never collides with a full skid slot
   assign m_free   = !out_valid | out_ready;
   assign acc      = in_valid & rdy;
   assign m_load   = m_free & (s_valid | acc);
   assign s_drop   = m_free & s_valid;
   assign s_load   = acc & out_valid & !out_ready;
   assign in_ready = rdy;
   always_ff @(posedge clk) begin
      if (rst | flush) rdy <= 1'b1;
      else rdy <= !(s_load | (s_valid & !s_drop));
   end
   pipe_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INST_W(INST_W), .NOP(NOP_INST)) u_m (
      .clk(clk), .rst(rst), .clear(flush), .load(m_load), .drop(m_free),
      .d_pc(s_valid ? s_pc : in_pc),
      .d_inst(s_valid ? s_inst : in_inst),
      .d_data0(s_valid ? s_data0 : in_data0),
      .d_data1(s_valid ? s_data1 : in_data1),
      .valid(out_valid), .pc(out_pc), .inst(out_inst), .data0(out_data0), .data1(out_data1)
   );
   pipe_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INST_W(INST_W), .NOP(NOP_INST)) u_s (
      .clk(clk), .rst(rst), .clear(flush), .load(s_load), .drop(s_drop),
      .d_pc(in_pc), .d_inst(in_inst), .d_data0(in_data0), .d_data1(in_data1),
      .valid(s_valid), .pc(s_pc), .inst(s_inst), .data0(s_data0), .data1(s_data1)
   );
`ifdef PIPE_STAGE_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cnt  <= '0;
         perf_bubble_cnt <= '0;
      end else begin
         if (out_valid & !out_ready & ~&perf_stall_cnt) perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (!out_valid & out_ready & ~&perf_bubble_cnt) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg: directed + random scoreboard bench for pipe_stage_skid_reg.
module tb_pipe_stage_skid_reg;
   typedef struct {
      logic [31:0] pc, inst, d0, d1;
   } ent_t;
   logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid;
   logic [14:0] in_pc = '0, out_pc;
   logic [31:0] in_inst = '0, in_data0 = '0, in_data1 = '0, out_inst, out_data0, out_data1;
`ifdef PIPE_STAGE_PERF_CNT_EN
   logic [31:0] perf_stall_cnt, perf_bubble_cnt;
`endif
   ent_t q[$];
   int   errors = 0, checks = 0;

   pipe_stage_skid_reg dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .in_data0(in_data0), .in_data1(in_data1),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
`ifdef PIPE_STAGE_PERF_CNT_EN
      .out_data0(out_data0), .out_data1(out_data1),
      .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`else
      .out_data0(out_data0), .out_data1(out_data1)
`endif
   );

   always #5 clk = ~clk;

   function automatic ent_t mk(input logic [14:0] pc);
      ent_t e;
      e.pc   = {17'h0, pc};
      e.inst = 32'hA500_0000 | {17'h0, pc};
      e.d0   = {17'h0, pc} * 32'd3 + 32'd7;
      e.d1   = ~{17'h0, pc};
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // drive one cycle from negedge; scoreboard pushes on accept, pops on take
   task automatic step(input logic iv, input logic [14:0] pc, input logic ordy, input logic fl);
      ent_t e, x;
      e = mk(pc);
      in_valid = iv; in_pc = pc; in_inst = e.inst; in_data0 = e.d0; in_data1 = e.d1;
      out_ready = ordy; flush = fl;
      #1;
      if (out_valid & out_ready) begin
         if (q.size() == 0) chk("unexpected_out_pc", {17'h0, out_pc}, 32'hFFFF_FFFF);
         else begin
            x = q.pop_front();
            chk("out_pc", {17'h0, out_pc}, x.pc);
            chk("out_inst", out_inst, x.inst);
            chk("out_data0", out_data0, x.d0);
            chk("out_data1", out_data1, x.d1);
         end
      end
      if (in_valid & in_ready & !flush) q.push_back(e);
      if (flush) q.delete();
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
   endtask

   initial begin
      in_valid = 1'b1; in_pc = 15'h99;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_out_inst", out_inst, 32'h00000013);
      chk("rst_out_pc", {17'h0, out_pc}, 32'h0);
      chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
      rst = 1'b0;
      // streaming, back to back
      step(1, 15'h10, 1, 0);
      chk("stream_v1", {31'h0, out_valid}, 32'h1);
      step(1, 15'h14, 1, 0);
      chk("stream_pc14", {17'h0, out_pc}, 32'h14);
      step(1, 15'h18, 1, 0);
      chk("stream_pc18", {17'h0, out_pc}, 32'h18);
      step(0, 15'h0, 1, 0);
      chk("stream_empty", {31'h0, out_valid}, 32'h0);
      // back-pressure
      step(1, 15'h20, 0, 0);
      chk("bp_rdy_after_1", {31'h0, in_ready}, 32'h1);
      step(1, 15'h24, 0, 0);
      chk("bp_rdy_after_2", {31'h0, in_ready}, 32'h0);
      step(1, 15'h28, 0, 0);
      chk("bp_hold_pc", {17'h0, out_pc}, 32'h20);
      chk("bp_rdy_held", {31'h0, in_ready}, 32'h0);
      step(1, 15'h28, 1, 0);
      chk("bp_rdy_back", {31'h0, in_ready}, 32'h1);
      step(1, 15'h28, 1, 0);
      step(0, 15'h0, 1, 0);
      chk("bp_drained", {31'h0, out_valid}, 32'h0);
      // flush with both slots full and a pending input
      step(1, 15'h30, 0, 0);
      step(1, 15'h34, 0, 0);
      step(1, 15'h38, 0, 1);
      chk("fl_out_valid", {31'h0, out_valid}, 32'h0);
      chk("fl_out_inst", out_inst, 32'h00000013);
      chk("fl_in_ready", {31'h0, in_ready}, 32'h1);
      chk("fl_pc_hold", {17'h0, out_pc}, 32'h30);
      step(0, 15'h0, 1, 0);
      step(0, 15'h0, 1, 0);
      // accept during flush is dropped
      step(1, 15'h3C, 1, 1);
      chk("fl_acc_drop", {31'h0, out_valid}, 32'h0);
      // take during flush still delivered
      step(1, 15'h50, 0, 0);
      step(0, 15'h0, 1, 1);
      chk("fl_take_v", {31'h0, out_valid}, 32'h0);
      // take with S full: 0x48 held upstream until S frees
      step(1, 15'h40, 0, 0);
      step(1, 15'h44, 0, 0);
      step(1, 15'h48, 1, 0);
      chk("sim_pc44", {17'h0, out_pc}, 32'h44);
      chk("sim_rdy", {31'h0, in_ready}, 32'h1);
      step(1, 15'h48, 1, 0);
      chk("sim_pc48", {17'h0, out_pc}, 32'h48);
      step(0, 15'h0, 1, 0);
      // random traffic
      for (int i = 0; i < 200; i++)
         step(1'($urandom_range(0, 1)), 15'(16'h100 + i * 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0));
      for (int i = 0; i < 10 && q.size() != 0; i++) step(0, 15'h0, 1, 0);
      chk("drain_q_empty", q.size(), 32'h0);
`ifdef PIPE_STAGE_PERF_CNT_EN
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      q.delete();
      chk("perf_rst_stall", perf_stall_cnt, 32'h0);
      step(1, 15'h60, 0, 0);
      repeat (5) step(0, 15'h0, 0, 0);
      chk("perf_stall5", perf_stall_cnt, 32'h5);
      step(0, 15'h0, 1, 1);
      chk("perf_stall_flush", perf_stall_cnt, 32'h5);
      chk("perf_bubble0", perf_bubble_cnt, 32'h0);
      step(0, 15'h0, 1, 0);
      step(0, 15'h0, 1, 0);
      chk("perf_bubble2", perf_bubble_cnt, 32'h2);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
